// File: rtl/aes_pkg.sv
// Shared definitions for the AES output buffer: block/word geometry,
// output FSM states and the block-to-word selection helper.
package aes_pkg;

    localparam int AES_BLK_W  = 128;
    localparam int AES_WORD_W = 32;
    localparam int AES_WORDS  = 4;

    // Word index of the final word of a block.
    localparam logic [1:0] WCNT_LAST = 2'(AES_WORDS - 1);

    typedef logic [AES_BLK_W-1:0]  aes_blk_t;
    typedef logic [AES_WORD_W-1:0] aes_word_t;

    typedef enum logic {
        OB_IDLE = 1'b0,
        OB_SEND = 1'b1
    } ob_state_e;

    // Word idx of a block in transmit order; lsw_first=1 starts at [31:0],
    // lsw_first=0 starts at [127:96].
    function automatic aes_word_t blk_word(input aes_blk_t   blk,
                                           input logic [1:0] idx,
                                           input bit         lsw_first);
        logic [1:0] sel;
        aes_word_t  w;
        sel = lsw_first ? idx : ~idx;
        case (sel)
            2'd0:    w = blk[31:0];
            2'd1:    w = blk[63:32];
            2'd2:    w = blk[95:64];
            default: w = blk[127:96];
        endcase
        return w;
    endfunction

endpackage

// File: rtl/aes_blk_fifo.sv
// Two-entry FIFO of 128-bit blocks. The caller guarantees it never pushes
// into a full FIFO without popping in the same cycle, nor pops when empty.
module aes_blk_fifo
    import aes_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push_i,
    input  logic                 pop_i,
    input  logic [AES_BLK_W-1:0] din_i,
    output logic [AES_BLK_W-1:0] head_o,
    output logic [1:0]           count_o
);

    aes_blk_t   r_mem [2];
    logic       r_head_ptr;
    logic       r_tail_ptr;
    logic [1:0] r_count;

    // Block storage write at the tail slot.
    // NOTE: storage is deliberately left without reset; nothing reads it
    // until a push has written it, and the outputs are masked by valid.
    always_ff @(posedge clk) begin
        if (push_i) begin
            r_mem[r_tail_ptr] <= din_i;
        end
    end

    // Pointer and occupancy bookkeeping.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head_ptr <= 1'b0;
            r_tail_ptr <= 1'b0;
            r_count    <= 2'd0;
        end else begin
            if (push_i) r_tail_ptr <= ~r_tail_ptr;
            if (pop_i)  r_head_ptr <= ~r_head_ptr;
            case ({push_i, pop_i})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign head_o  = r_mem[r_head_ptr];
    assign count_o = r_count;

endmodule

// File: rtl/aes_output_buffer.sv
// Buffers finished AES blocks and streams them out as 32-bit words under a
// valid/ready handshake; drops a block (with an ovf pulse) when both entries
// are occupied and nothing leaves that cycle.
module aes_output_buffer
    import aes_pkg::*;
#(
    parameter bit LSW_FIRST = 1'b1
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  done_i,
    input  logic [AES_BLK_W-1:0]  text_i,
    input  logic                  ready_i,
    output logic [AES_WORD_W-1:0] text_o,
    output logic                  valid_o,
    output logic                  last_o,
    output logic                  full_o,
    output logic                  ovf_o
);

    ob_state_e  r_state;
    ob_state_e  w_state_nxt;
    logic [1:0] r_wcnt;
    logic [1:0] w_wcnt_nxt;
    logic       r_ovf;

    logic       w_valid;
    logic       w_xfer;
    logic       w_pop;
    logic       w_push;
    logic       w_drop;
    logic [1:0] w_count;
    aes_blk_t   w_head;

    aes_blk_fifo u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .din_i   (text_i),
        .head_o  (w_head),
        .count_o (w_count)
    );

    // Handshake decode: a pop frees a slot in the same cycle, so a full
    // FIFO still accepts a block arriving on the final-word transfer.
    always_comb begin
        w_valid = (r_state == OB_SEND);
        w_xfer  = w_valid && ready_i;
        w_pop   = w_xfer && (r_wcnt == WCNT_LAST);
        w_push  = done_i && ((w_count != 2'd2) || w_pop);
        w_drop  = done_i && !w_push;
    end

    // Next-state and word-counter logic.
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned, which would infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_wcnt_nxt  = r_wcnt;
        case (r_state)
            OB_IDLE: begin
                if (w_push) w_state_nxt = OB_SEND;
            end
            OB_SEND: begin
                if (w_xfer) w_wcnt_nxt = r_wcnt + 2'd1;
                if (w_pop && (w_count == 2'd1) && !w_push) w_state_nxt = OB_IDLE;
            end
            default: w_state_nxt = OB_IDLE;
        endcase
    end

    // FSM state, word counter and registered overflow pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= OB_IDLE;
            r_wcnt  <= 2'd0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_wcnt  <= w_wcnt_nxt;
            r_ovf   <= w_drop;
        end
    end

    // Output word mux, zeroed whenever no valid word is presented.
    always_comb begin
        valid_o = w_valid;
        text_o  = w_valid ? blk_word(w_head, r_wcnt, LSW_FIRST) : '0;
        last_o  = w_valid && (r_wcnt == WCNT_LAST);
        full_o  = (w_count == 2'd2);
        ovf_o   = r_ovf;
    end

endmodule

// File: tb/tb_aes_output_buffer.sv
// Directed testbench for aes_output_buffer: basic streaming, backpressure,
// overflow, push/pop on the final word, async reset and word order.
module tb_aes_output_buffer;

    logic         clk = 1'b0;
    logic         rst;
    logic         done_i;
    logic [127:0] text_i;
    logic         ready_i;

    logic [31:0]  text_o,  text1_o;
    logic         valid_o, valid1_o;
    logic         last_o,  last1_o;
    logic         full_o,  full1_o;
    logic         ovf_o,   ovf1_o;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [127:0] BLK   = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] BLK_A = 128'hAAAA0003_AAAA0002_AAAA0001_AAAA0000;
    localparam logic [127:0] BLK_B = 128'hBBBB0003_BBBB0002_BBBB0001_BBBB0000;
    localparam logic [127:0] BLK_C = 128'hCCCC0003_CCCC0002_CCCC0001_CCCC0000;

    logic [31:0] blk_lsw [4] = '{32'hCCDDEEFF, 32'h8899AABB, 32'h44556677, 32'h00112233};
    logic [31:0] blk_msw [4] = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};

    aes_output_buffer #(.LSW_FIRST(1'b1)) dut (
        .clk     (clk),
        .rst     (rst),
        .done_i  (done_i),
        .text_i  (text_i),
        .ready_i (ready_i),
        .text_o  (text_o),
        .valid_o (valid_o),
        .last_o  (last_o),
        .full_o  (full_o),
        .ovf_o   (ovf_o)
    );

    aes_output_buffer #(.LSW_FIRST(1'b0)) dut_msw (
        .clk     (clk),
        .rst     (rst),
        .done_i  (done_i),
        .text_i  (text_i),
        .ready_i (ready_i),
        .text_o  (text1_o),
        .valid_o (valid1_o),
        .last_o  (last1_o),
        .full_o  (full1_o),
        .ovf_o   (ovf1_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock and sample 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_word(input string tag, input logic [31:0] exp, input logic exp_last);
        check({tag, ".valid"}, 32'(valid_o), 32'd1);
        check({tag, ".text"},  text_o, exp);
        check({tag, ".last"},  32'(last_o), 32'(exp_last));
    endtask

    // Expected word w of a block whose word i is base|i (lsw-first order).
    function automatic logic [31:0] tagged_word(input logic [127:0] blk, input int w);
        logic [127:0] t;
        t = blk >> (32 * w);
        return t[31:0];
    endfunction

    initial begin
        rst     = 1'b0;
        done_i  = 1'b0;
        text_i  = '0;
        ready_i = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst.valid", 32'(valid_o), 32'd0);
        check("rst.text",  text_o, 32'd0);
        check("rst.last",  32'(last_o), 32'd0);
        check("rst.full",  32'(full_o), 32'd0);
        check("rst.ovf",   32'(ovf_o), 32'd0);
        rst = 1'b1;
        tick();

        // Basic streaming, one-cycle latency
        text_i  = BLK;
        done_i  = 1'b1;
        ready_i = 1'b1;
        check("basic.pre_valid", 32'(valid_o), 32'd0);
        tick();
        done_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            expect_word($sformatf("basic.w%0d", i), blk_lsw[i], i == 3);
            tick();
        end
        check("basic.end_valid", 32'(valid_o), 32'd0);
        check("basic.end_text",  text_o, 32'd0);

        // Backpressure at wcnt=1
        done_i = 1'b1;
        tick();
        done_i = 1'b0;
        expect_word("bp.w0", blk_lsw[0], 1'b0);
        tick();
        ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            expect_word($sformatf("bp.stall%0d", i), blk_lsw[1], 1'b0);
            tick();
        end
        ready_i = 1'b1;
        for (int i = 1; i < 4; i++) begin
            expect_word($sformatf("bp.w%0d", i), blk_lsw[i], i == 3);
            tick();
        end
        check("bp.end_valid", 32'(valid_o), 32'd0);

        // Overflow: A, B queued, C dropped
        ready_i = 1'b0;
        text_i  = BLK_A;
        done_i  = 1'b1;
        tick();
        check("ovf.full_after_a", 32'(full_o), 32'd0);
        text_i = BLK_B;
        tick();
        check("ovf.full_after_b", 32'(full_o), 32'd1);
        check("ovf.no_ovf_b",     32'(ovf_o), 32'd0);
        text_i = BLK_C;
        tick();
        done_i = 1'b0;
        check("ovf.pulse", 32'(ovf_o), 32'd1);
        check("ovf.full_c", 32'(full_o), 32'd1);
        tick();
        check("ovf.pulse_end", 32'(ovf_o), 32'd0);
        ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            expect_word($sformatf("ovf.a%0d", i), tagged_word(BLK_A, i), i == 3);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            expect_word($sformatf("ovf.b%0d", i), tagged_word(BLK_B, i), i == 3);
            tick();
        end
        check("ovf.end_valid", 32'(valid_o), 32'd0);

        // Push on the final-word transfer while full
        ready_i = 1'b0;
        text_i  = BLK_A;
        done_i  = 1'b1;
        tick();
        text_i = BLK_B;
        tick();
        done_i = 1'b0;
        check("sim.full", 32'(full_o), 32'd1);
        ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            expect_word($sformatf("sim.a%0d", i), tagged_word(BLK_A, i), i == 3);
            if (i == 3) begin
                text_i = BLK_C;
                done_i = 1'b1;
            end
            tick();
        end
        done_i = 1'b0;
        check("sim.no_ovf", 32'(ovf_o), 32'd0);
        check("sim.full_kept", 32'(full_o), 32'd1);
        for (int i = 0; i < 4; i++) begin
            expect_word($sformatf("sim.b%0d", i), tagged_word(BLK_B, i), i == 3);
            tick();
        end
        check("sim.full_drop", 32'(full_o), 32'd0);
        for (int i = 0; i < 4; i++) begin
            expect_word($sformatf("sim.c%0d", i), tagged_word(BLK_C, i), i == 3);
            tick();
        end
        check("sim.end_valid", 32'(valid_o), 32'd0);

        // Asynchronous reset mid-block
        text_i = BLK;
        done_i = 1'b1;
        tick();
        done_i = 1'b0;
        tick();
        tick();
        expect_word("rstm.w2", blk_lsw[2], 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check("rstm.valid", 32'(valid_o), 32'd0);
        check("rstm.text",  text_o, 32'd0);
        check("rstm.last",  32'(last_o), 32'd0);
        check("rstm.valid_msw", 32'(valid1_o), 32'd0);
        tick();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("rstm.idle%0d", i), 32'(valid_o), 32'd0);
        end

        // Word order for both parameter settings
        text_i = BLK;
        done_i = 1'b1;
        tick();
        done_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("msw.w%0d", i), text1_o, blk_msw[i]);
            check($sformatf("msw.last%0d", i), 32'(last1_o), 32'(i == 3));
            check($sformatf("lsw.w%0d", i), text_o, blk_lsw[i]);
            tick();
        end
        check("msw.end_valid", 32'(valid1_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_output_buffer.md
AES_OUTPUT_BUFFER -- requirements
Module: aes_output_buffer

Interface
REQ-001 The block SHALL have parameter LSW_FIRST, default 1; 1 sends bits [31:0] first, 0 sends bits [127:96] first.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port done_i, input, 1 bit: one-cycle pulse from the core marking text_i as a finished block.
REQ-005 The block SHALL have port text_i, input, 128 bits: cipher/plain result, sampled only when done_i=1.
REQ-006 The block SHALL have port ready_i, input, 1 bit: the downstream sink can take a word this cycle.
REQ-007 The block SHALL have port text_o, output, 32 bits: current output word.
REQ-008 The block SHALL have port valid_o, output, 1 bit: text_o holds a valid word.
REQ-009 The block SHALL have port last_o, output, 1 bit: text_o is the 4th word of a block.
REQ-010 The block SHALL have port full_o, output, 1 bit: both block entries are occupied.
REQ-011 The block SHALL have port ovf_o, output, 1 bit: one-cycle pulse when a block is dropped.

Function
REQ-012 The block SHALL hold a 2-entry FIFO of 128-bit blocks with head/tail pointers and a 2-bit occupancy count (0..2).
REQ-013 A push SHALL occur when done_i=1 and (count<2, or a block is popped in the same cycle).
REQ-014 If done_i=1 while count=2 and no block is popped that cycle, the block SHALL drop text_i, pulse ovf_o for one cycle, and leave FIFO contents unchanged.
REQ-015 A word transfer SHALL occur on a cycle where valid_o=1 and ready_i=1.
REQ-016 The FSM SHALL have states IDLE (count=0) and SEND (count>0), with a 2-bit word counter wcnt.
REQ-017 IDLE->SEND SHALL occur on a push; SEND->IDLE SHALL occur on the transfer with wcnt=3 when count=1 and there is no push that cycle.
REQ-018 valid_o SHALL equal 1 exactly in SEND; latency from done_i in IDLE to valid_o is 1 cycle.
REQ-019 text_o SHALL be head-entry word wcnt (word0=[31:0] when LSW_FIRST=1, word0=[127:96] when LSW_FIRST=0), and SHALL be 0 when valid_o=0.
REQ-020 While valid_o=1 and ready_i=0, text_o, last_o, and wcnt SHALL hold stable.
REQ-021 Each transfer SHALL increment wcnt modulo 4; the transfer at wcnt=3 SHALL pop the head block and wrap wcnt to 0.
REQ-022 last_o SHALL equal valid_o AND (wcnt==3).
REQ-023 On a push and pop in the same cycle, count SHALL remain unchanged; when count was 1, the pushed block SHALL become head and streaming SHALL continue without a bubble cycle.
REQ-024 full_o SHALL equal (count==2), registered with no combinational path from done_i.
REQ-025 Back-to-back blocks SHALL stream gap-free: 8 consecutive transfers for 2 queued blocks with ready_i held at 1.

Reset
REQ-026 rst=0 SHALL asynchronously force the FSM to IDLE, count=0, wcnt=0, and both pointers to 0.
REQ-027 Under reset, valid_o, last_o, full_o, and ovf_o SHALL be 0, and text_o SHALL be 32'h0.
REQ-028 Reset asserted mid-block SHALL discard all queued data; after release, no residual words SHALL be emitted.
REQ-029 FIFO data storage SHALL need no reset; outputs SHALL be masked by valid_o.

Structure
REQ-030 Shared package aes_pkg SHALL hold AES_BLK_W=128, AES_WORD_W=32, AES_WORDS=4, and the output FSM state enum (OB_IDLE, OB_SEND).
REQ-031 The 2-entry storage with its pointers and count SHALL be one sub-module, aes_blk_fifo; the FSM, word mux, and overflow logic SHALL stay in aes_output_buffer.

Verification
REQ-032 Basic: with LSW_FIRST=1, done_i pulse with text_i=128'h00112233_44556677_8899AABB_CCDDEEFF and ready_i=1 -> text_o=CCDDEEFF, 8899AABB, 44556677, 00112233 on cycles N+1..N+4, last_o high only on the 4th, valid_o low at N+5.
REQ-033 Backpressure: same block, ready_i=0 for 3 cycles at wcnt=1 -> text_o holds 8899AABB stable and valid_o stays 1 while stalled; the full sequence completes after ready_i returns to 1.
REQ-034 Overflow: ready_i=0, three done_i pulses with blocks A, B, C -> full_o=1 after B, one ovf_o pulse on C, only A then B streamed afterwards.
REQ-035 Simultaneous: count=2 and done_i on the wcnt=3 transfer cycle -> no ovf_o, count stays 2, and the new block streams third.
REQ-036 Reset mid-stream: rst low at wcnt=2 -> valid_o=0 and text_o=0 immediately (asynchronous); with no new done_i after release, valid_o stays 0; with LSW_FIRST=0, the REQ-032 block streams 00112233 first.
